// File: rtl/cpu_pkg.sv
// Shared types and constants for the 6502 instruction front end.
package cpu_pkg;

    localparam int               CYC_W   = 3;
    localparam logic [CYC_W-1:0] CYC_MAX = 3'd7;
    localparam logic [7:0]       BRK_OP  = 8'h00;

    // Origin of the instruction currently held in the IR.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        RST  = 2'd1,
        NMI  = 2'd2,
        IRQ  = 2'd3
    } src_t;

    // Timing FSM: RSTSEQ runs the reset BRK without loading the IR.
    typedef enum logic {
        RSTSEQ = 1'b0,
        RUN    = 1'b1
    } tstate_t;

    typedef struct packed {
        logic [7:0] op;
        src_t       src;
    } fetch_t;

    // Opcode selection at a fetch edge: pending NMI, then unmasked IRQ,
    // then the byte on the data bus.
    function automatic fetch_t fetch_select(input logic       nmi_pend,
                                            input logic       irq_n,
                                            input logic       iflag,
                                            input logic [7:0] databus);
        fetch_t f;
        if (nmi_pend) begin
            f.op  = BRK_OP;
            f.src = NMI;
        end else if (!irq_n && !iflag) begin
            f.op  = BRK_OP;
            f.src = IRQ;
        end else begin
            f.op  = databus;
            f.src = NONE;
        end
        return f;
    endfunction

endpackage

// File: rtl/inst_timing_nmi_detect.sv
// NMI detector: falling-edge latch (or plain level sample in test mode).
// Runs every clock regardless of rdy so edges are never missed while stalled.
module nmi_detect #(
    parameter bit NMI_EDGE = 1'b1
) (
    input  logic clk,
    input  logic clr_n,
    input  logic nmi_n,
    input  logic take,
    output logic pend
);

    logic nmi_d;

    // Previous nmi_n sample; resets high so a line held low through reset
    // is seen as a fresh edge on the first clock.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            nmi_d <= 1'b1;
        end else begin
            nmi_d <= nmi_n;
        end
    end

    // Pending flag; a new edge wins over a same-cycle take.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pend <= 1'b0;
        end else if (NMI_EDGE) begin
            if (nmi_d && !nmi_n) begin
                pend <= 1'b1;
            end else if (take) begin
                pend <= 1'b0;
            end
        end else begin
            pend <= !nmi_n;
        end
    end

endmodule

// File: rtl/inst_timing.sv
// Instruction register and cycle-timing generator feeding instdecode.
//
// state  | meaning
// RSTSEQ | reset BRK in progress; fetch does not load the IR
// RUN    | normal operation; IR loaded at every fetch edge
module inst_timing
    import cpu_pkg::*;
#(
    parameter bit NMI_EDGE = 1'b1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             rdy,
    input  logic [7:0]       databus,
    input  logic             res,
    input  logic             iflag,
    input  logic             irq_n,
    input  logic             nmi_n,
    output logic [7:0]       inst,
    output logic [CYC_W-1:0] cyc,
    output logic             sync,
    output logic [1:0]       src
);

    tstate_t          state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [7:0]       inst_q, inst_d;
    src_t             src_q, src_d;

    logic   end_inst;
    logic   fetch_edge;
    logic   nmi_pend;
    logic   take_nmi;
    fetch_t sel;

    // res during the fetch cycle is ignored; cycle 7 wraps as if res were set.
    assign end_inst   = (res && (cyc_q != '0)) || (cyc_q == CYC_MAX);
    assign fetch_edge = rdy && (state_q == RUN) && (cyc_q == '0);
    assign sel        = fetch_select(nmi_pend, irq_n, iflag, databus);
    assign take_nmi   = fetch_edge && nmi_pend;

    nmi_detect #(
        .NMI_EDGE (NMI_EDGE)
    ) u_nmi_detect (
        .clk   (clk),
        .clr_n (clr_n),
        .nmi_n (nmi_n),
        .take  (take_nmi),
        .pend  (nmi_pend)
    );

    // Next-state: cycle counter, IR/source load and FSM; rdy=0 holds all.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        inst_d  = inst_q;
        src_d   = src_q;
        if (rdy) begin
            cyc_d = end_inst ? '0 : cyc_q + 3'd1;
            case (state_q)
                RSTSEQ: begin
                    if (end_inst) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (cyc_q == '0) begin
                        inst_d = sel.op;
                        src_d  = sel.src;
                    end
                end
                default: state_d = RSTSEQ;
            endcase
        end
    end

    // State registers; reset starts a forced BRK from cycle 0.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= RSTSEQ;
            cyc_q   <= '0;
            inst_q  <= BRK_OP;
            src_q   <= RST;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            inst_q  <= inst_d;
            src_q   <= src_d;
        end
    end

    assign inst = inst_q;
    assign cyc  = cyc_q;
    assign src  = src_q;
    assign sync = (cyc_q == '0);

endmodule

// File: tb/tb_inst_timing.sv
// Bench for inst_timing: directed vector table, hand sequences for async
// reset, and randomized stimulus against a cycle-level reference model.
module tb_inst_timing;

    localparam logic [1:0] S_NONE = 2'd0;
    localparam logic [1:0] S_RST  = 2'd1;
    localparam logic [1:0] S_NMI  = 2'd2;
    localparam logic [1:0] S_IRQ  = 2'd3;

    logic       clk = 1'b0;
    logic       clr_n, rdy, res, iflag, irq_n, nmi_n;
    logic [7:0] databus;
    logic [7:0] inst;
    logic [2:0] cyc;
    logic       sync;
    logic [1:0] src;

    int n_vec = 0;
    int n_err = 0;

    inst_timing #(.NMI_EDGE(1'b1)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .rdy     (rdy),
        .databus (databus),
        .res     (res),
        .iflag   (iflag),
        .irq_n   (irq_n),
        .nmi_n   (nmi_n),
        .inst    (inst),
        .cyc     (cyc),
        .sync    (sync),
        .src     (src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rdy;
        logic [7:0] db;
        logic       res;
        logic       iflag;
        logic       irq_n;
        logic       nmi_n;
        logic [7:0] e_inst;
        logic [2:0] e_cyc;
        logic [1:0] e_src;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [7:0] d, input logic rs,
                                input logic ifl, input logic irqn, input logic nmin,
                                input logic [7:0] ei, input logic [2:0] ec,
                                input logic [1:0] es);
        vec_t v;
        v.rdy = r; v.db = d; v.res = rs; v.iflag = ifl; v.irq_n = irqn; v.nmi_n = nmin;
        v.e_inst = ei; v.e_cyc = ec; v.e_src = es;
        return v;
    endfunction

    task automatic addv(input logic r, input logic [7:0] d, input logic rs,
                        input logic ifl, input logic irqn, input logic nmin,
                        input logic [7:0] ei, input logic [2:0] ec, input logic [1:0] es);
        tbl.push_back(mk(r, d, rs, ifl, irqn, nmin, ei, ec, es));
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] ei,
                             input logic [2:0] ec, input logic [1:0] es);
        chk({tag, ".inst"}, inst, ei);
        chk({tag, ".cyc"},  {5'd0, cyc}, {5'd0, ec});
        chk({tag, ".src"},  {6'd0, src}, {6'd0, es});
        chk({tag, ".sync"}, {7'd0, sync}, {7'd0, (ec == 3'd0)});
    endtask

    task automatic apply(input vec_t v, input string tag);
        rdy = v.rdy; databus = v.db; res = v.res;
        iflag = v.iflag; irq_n = v.irq_n; nmi_n = v.nmi_n;
        @(posedge clk);
        #1;
        check_all(tag, v.e_inst, v.e_cyc, v.e_src);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0;
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
    endtask

    // Reference model: instruction-level view of the timing generator.
    int         m_cyc;
    bit         m_boot;
    logic [7:0] m_inst;
    logic [1:0] m_src;
    bit         m_nmi_prev;
    bit         m_nmi_req;

    function automatic void model_reset();
        m_cyc = 0; m_boot = 1; m_inst = 8'h00; m_src = S_RST;
        m_nmi_prev = 1; m_nmi_req = 0;
    endfunction

    function automatic void model_step();
        bit boundary, is_fetch, new_req;
        boundary = (m_cyc == 7) || (res && m_cyc != 0);
        is_fetch = rdy && !m_boot && (m_cyc == 0);
        if (m_nmi_prev && !nmi_n)       new_req = 1;
        else if (is_fetch && m_nmi_req) new_req = 0;
        else                            new_req = m_nmi_req;
        if (is_fetch) begin
            if (m_nmi_req)             begin m_inst = 8'h00;   m_src = S_NMI;  end
            else if (!irq_n && !iflag) begin m_inst = 8'h00;   m_src = S_IRQ;  end
            else                       begin m_inst = databus; m_src = S_NONE; end
        end
        if (rdy) begin
            if (m_boot && boundary) m_boot = 0;
            m_cyc = boundary ? 0 : (m_cyc + 1) % 8;
        end
        m_nmi_req  = new_req;
        m_nmi_prev = nmi_n;
    endfunction

    initial begin
        clr_n = 1'b0; rdy = 1'b1; databus = 8'hA9; res = 1'b0;
        iflag = 1'b1; irq_n = 1'b1; nmi_n = 1'b1;

        // Reset BRK: IR stays 00/RST until res ends it at cycle 6.
        for (int i = 0; i < 6; i++) addv(1, 8'hA9, 0, 1, 1, 1, 8'h00, 3'(i + 1), S_RST);
        addv(1, 8'hA9, 1, 1, 1, 1, 8'h00, 3'd0, S_RST);
        addv(1, 8'hA9, 0, 1, 1, 1, 8'hA9, 3'd1, S_NONE);
        addv(1, 8'hA9, 0, 1, 1, 1, 8'hA9, 3'd2, S_NONE);
        addv(1, 8'hA9, 1, 1, 1, 1, 8'hA9, 3'd0, S_NONE);
        // Forced wrap after cycle 7.
        addv(1, 8'h4C, 0, 1, 1, 1, 8'h4C, 3'd1, S_NONE);
        for (int i = 2; i < 8; i++) addv(1, 8'h4C, 0, 1, 1, 1, 8'h4C, 3'(i), S_NONE);
        addv(1, 8'h4C, 0, 1, 1, 1, 8'h4C, 3'd0, S_NONE);
        addv(1, 8'h60, 0, 1, 1, 1, 8'h60, 3'd1, S_NONE);
        // rdy stall at cycle 2.
        addv(1, 8'h60, 0, 1, 1, 1, 8'h60, 3'd2, S_NONE);
        for (int i = 0; i < 3; i++) addv(0, 8'hFF, 1, 0, 0, 1, 8'h60, 3'd2, S_NONE);
        addv(1, 8'hFF, 0, 1, 1, 1, 8'h60, 3'd3, S_NONE);
        addv(1, 8'hFF, 1, 1, 1, 1, 8'h60, 3'd0, S_NONE);
        // IRQ masked, then taken.
        addv(1, 8'hEA, 0, 1, 0, 1, 8'hEA, 3'd1, S_NONE);
        addv(1, 8'hEA, 1, 1, 1, 1, 8'hEA, 3'd0, S_NONE);
        addv(1, 8'hEA, 0, 0, 0, 1, 8'h00, 3'd1, S_IRQ);
        addv(1, 8'hEA, 1, 1, 1, 1, 8'h00, 3'd0, S_IRQ);
        // res during fetch is ignored.
        addv(1, 8'h18, 1, 1, 1, 1, 8'h18, 3'd1, S_NONE);
        addv(1, 8'h18, 1, 1, 1, 1, 8'h18, 3'd0, S_NONE);
        // NMI edge at cycle 3 with IRQ also asserted: NMI first, then IRQ.
        addv(1, 8'hEA, 0, 1, 1, 1, 8'hEA, 3'd1, S_NONE);
        addv(1, 8'hEA, 0, 1, 1, 1, 8'hEA, 3'd2, S_NONE);
        addv(1, 8'hEA, 0, 1, 1, 1, 8'hEA, 3'd3, S_NONE);
        addv(1, 8'hEA, 0, 0, 0, 0, 8'hEA, 3'd4, S_NONE);
        addv(1, 8'hEA, 0, 0, 0, 1, 8'hEA, 3'd5, S_NONE);
        addv(1, 8'hEA, 1, 0, 0, 1, 8'hEA, 3'd0, S_NONE);
        addv(1, 8'hEA, 0, 0, 0, 1, 8'h00, 3'd1, S_NMI);
        addv(1, 8'hEA, 1, 0, 0, 1, 8'h00, 3'd0, S_NMI);
        addv(1, 8'hEA, 0, 0, 0, 1, 8'h00, 3'd1, S_IRQ);
        addv(1, 8'hEA, 1, 1, 1, 1, 8'h00, 3'd0, S_IRQ);
        // NMI edge while stalled is still caught.
        addv(1, 8'hC8, 0, 1, 1, 1, 8'hC8, 3'd1, S_NONE);
        addv(0, 8'hC8, 0, 1, 1, 0, 8'hC8, 3'd1, S_NONE);
        addv(0, 8'hC8, 0, 1, 1, 1, 8'hC8, 3'd1, S_NONE);
        addv(1, 8'hC8, 1, 1, 1, 1, 8'hC8, 3'd0, S_NONE);
        addv(1, 8'hC8, 0, 1, 1, 1, 8'h00, 3'd1, S_NMI);
        addv(1, 8'hC8, 1, 1, 1, 1, 8'h00, 3'd0, S_NMI);
        // Edge in the last execute cycle is taken at the very next fetch.
        addv(1, 8'hC8, 0, 1, 1, 1, 8'hC8, 3'd1, S_NONE);
        addv(1, 8'hC8, 1, 1, 1, 0, 8'hC8, 3'd0, S_NONE);
        addv(1, 8'hC8, 0, 1, 1, 1, 8'h00, 3'd1, S_NMI);
        addv(1, 8'hC8, 1, 1, 1, 1, 8'h00, 3'd0, S_NMI);
        // Edge during the fetch cycle itself waits for the following fetch.
        addv(1, 8'hC8, 0, 1, 1, 0, 8'hC8, 3'd1, S_NONE);
        addv(1, 8'hC8, 1, 1, 1, 1, 8'hC8, 3'd0, S_NONE);
        addv(1, 8'hC8, 0, 1, 1, 1, 8'h00, 3'd1, S_NMI);
        addv(1, 8'hC8, 1, 1, 1, 1, 8'h00, 3'd0, S_NMI);

        do_reset();
        #1;
        check_all("reset", 8'h00, 3'd0, S_RST);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "table");

        // Asynchronous reset in the middle of cycle 4.
        apply(mk(1, 8'h8D, 0, 1, 1, 1, 8'h8D, 3'd1, S_NONE), "pre_rst");
        apply(mk(1, 8'h8D, 0, 1, 1, 1, 8'h8D, 3'd2, S_NONE), "pre_rst");
        apply(mk(1, 8'h8D, 0, 1, 1, 1, 8'h8D, 3'd3, S_NONE), "pre_rst");
        apply(mk(1, 8'h8D, 0, 1, 1, 1, 8'h8D, 3'd4, S_NONE), "pre_rst");
        #2;
        clr_n = 1'b0;
        #1;
        check_all("async_rst", 8'h00, 3'd0, S_RST);
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        apply(mk(1, 8'hA9, 0, 1, 1, 1, 8'h00, 3'd1, S_RST), "post_rst");
        apply(mk(1, 8'hA9, 0, 1, 1, 1, 8'h00, 3'd2, S_RST), "post_rst");
        apply(mk(0, 8'hA9, 1, 1, 1, 1, 8'h00, 3'd2, S_RST), "post_rst");
        apply(mk(1, 8'hA9, 1, 1, 1, 1, 8'h00, 3'd0, S_RST), "post_rst");
        apply(mk(1, 8'hA9, 0, 1, 1, 1, 8'hA9, 3'd1, S_NONE), "post_rst");

        // Randomized run; nmi_n is held low through reset to exercise nmi_d's
        // reset value.
        nmi_n = 1'b0;
        do_reset();
        model_reset();
        #1;
        check_all("rand_reset", m_inst, 3'(m_cyc), m_src);
        for (int i = 0; i < 3000; i++) begin
            rdy     = ($urandom_range(0, 7) != 0);
            res     = ($urandom_range(0, 3) == 0);
            iflag   = 1'($urandom_range(0, 1));
            irq_n   = ($urandom_range(0, 2) != 0);
            nmi_n   = (i == 0) ? 1'b0 : ($urandom_range(0, 19) != 0);
            databus = 8'($urandom_range(0, 255));
            @(posedge clk);
            model_step();
            #1;
            check_all("rand", m_inst, 3'(m_cyc), m_src);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
